// File: rtl/rand_matrix_seq_if.sv
// Request and element-stream handshake between a matrix consumer and rand_matrix_seq.
// master = requester/consumer side, slave = sequencer side.
interface rand_matrix_seq_if #(
    parameter int ELEM_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_rows;
    logic [2:0]        req_cols;
    logic [7:0]        req_max;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic [2:0]        out_row;
    logic [2:0]        out_col;
    logic              out_last;

    modport master (
        output req_valid, req_rows, req_cols, req_max, out_ready,
        input  req_ready, out_valid, out_data, out_row, out_col, out_last
    );

    modport slave (
        input  req_valid, req_rows, req_cols, req_max, out_ready,
        output req_ready, out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/rand_matrix_seq.sv
// Random-matrix sequencer: programs the scaled random unit, stirs it for STIR_CYCLES,
// snapshots all lanes, then streams rows*cols elements in row-major order.
module rand_matrix_seq #(
    parameter int ELEM_W      = 8,
    parameter int MAX_DIM     = 5,
    parameter int STIR_CYCLES = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    rand_matrix_seq_if.slave                  bus,
    input  logic                              abort,
    output logic                              gen_enable,
    output logic [7:0]                        gen_max_val,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] rand_data,
    output logic                              busy,
    output logic                              err_dim
);
    localparam int LANES = MAX_DIM * MAX_DIM;

    typedef enum logic [1:0] {IDLE, STIR, CAPTURE, STREAM} state_t;

    state_t                    state_q;
    logic [3:0]                stir_cnt_q;
    logic [2:0]                rows_q, cols_q;
    logic [2:0]                row_q, col_q;
    logic [LANES*ELEM_W-1:0]   buf_q;
    logic                      gen_enable_q;
    logic [7:0]                gen_max_q;
    logic                      err_dim_q;
    logic                      out_valid_q;
    logic                      out_last_q;
    logic [ELEM_W-1:0]         out_data_q;

    logic                      last_col_d;
    logic [2:0]                row_d, col_d;
    logic                      xfer;
    logic                      req_ok;

    function automatic logic dim_ok(input logic [2:0] d);
        return (d != 3'd0) && (int'(d) <= MAX_DIM);
    endfunction

    // Linear packing: element (r,c) of an n-column matrix lives in lane r*n+c.
    function automatic logic [ELEM_W-1:0] lane_sel(input logic [LANES*ELEM_W-1:0] b,
                                                    input logic [2:0] r,
                                                    input logic [2:0] c,
                                                    input logic [2:0] n);
        int k;
        k = int'(r) * int'(n) + int'(c);
        return b[k*ELEM_W +: ELEM_W];
    endfunction

    always_comb begin
        last_col_d = (col_q == cols_q - 3'd1);
        col_d      = last_col_d ? 3'd0 : col_q + 3'd1;
        row_d      = last_col_d ? row_q + 3'd1 : row_q;
        xfer       = out_valid_q && bus.out_ready;
        req_ok     = dim_ok(bus.req_rows) && dim_ok(bus.req_cols);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            stir_cnt_q   <= 4'd0;
            rows_q       <= 3'd0;
            cols_q       <= 3'd0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            buf_q        <= '0;
            gen_enable_q <= 1'b0;
            gen_max_q    <= 8'd0;
            err_dim_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            err_dim_q <= 1'b0;
            // Abort outranks every transition; an element handed over on this edge still counts.
            if (abort && state_q != IDLE) begin
                state_q      <= IDLE;
                gen_enable_q <= 1'b0;
                out_valid_q  <= 1'b0;
                out_last_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.req_valid) begin
                            if (req_ok) begin
                                rows_q       <= bus.req_rows;
                                cols_q       <= bus.req_cols;
                                gen_max_q    <= bus.req_max;
                                stir_cnt_q   <= 4'(STIR_CYCLES);
                                gen_enable_q <= 1'b1;
                                state_q      <= STIR;
                            end else begin
                                err_dim_q <= 1'b1;
                            end
                        end
                    end
                    STIR: begin
                        stir_cnt_q <= stir_cnt_q - 4'd1;
                        if (stir_cnt_q == 4'd1) begin
                            gen_enable_q <= 1'b0;
                            state_q      <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        buf_q       <= rand_data;
                        row_q       <= 3'd0;
                        col_q       <= 3'd0;
                        out_data_q  <= rand_data[ELEM_W-1:0];
                        out_last_q  <= (rows_q == 3'd1) && (cols_q == 3'd1);
                        out_valid_q <= 1'b1;
                        state_q     <= STREAM;
                    end
                    STREAM: begin
                        if (xfer) begin
                            if (out_last_q) begin
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                                state_q     <= IDLE;
                            end else begin
                                row_q      <= row_d;
                                col_q      <= col_d;
                                out_data_q <= lane_sel(buf_q, row_d, col_d, cols_q);
                                out_last_q <= (row_d == rows_q - 3'd1) && (col_d == cols_q - 3'd1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;
    assign bus.out_last  = out_last_q;
    assign gen_enable    = gen_enable_q;
    assign gen_max_val   = gen_max_q;
    assign err_dim       = err_dim_q;
endmodule

// File: tb/tb_rand_matrix_seq.sv
// Directed bench for rand_matrix_seq with a stub lane source and an LFSR-based random unit.
module tb_rand_matrix_seq;
    localparam int ELEM_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int STIR    = 3;
    localparam int LANES   = MAX_DIM * MAX_DIM;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    abort = 1'b0;
    logic                    use_real = 1'b0;
    logic                    gen_enable;
    logic [7:0]              gen_max_val;
    logic                    busy;
    logic                    err_dim;
    logic [LANES*ELEM_W-1:0] rand_data;
    logic [LANES*ELEM_W-1:0] stub_data;
    logic [LANES*ELEM_W-1:0] real_data;
    logic [7:0]              lfsr [LANES];
    int                      vectors = 0;
    int                      miscompares = 0;

    rand_matrix_seq_if #(.ELEM_W(ELEM_W)) bus ();

    rand_matrix_seq #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM), .STIR_CYCLES(STIR)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .abort       (abort),
        .gen_enable  (gen_enable),
        .gen_max_val (gen_max_val),
        .rand_data   (rand_data),
        .busy        (busy),
        .err_dim     (err_dim)
    );

    always #5 clk = ~clk;

    // Scaled random unit: per-lane 8-bit LFSR stepped by gen_enable, scaled to 0..max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) lfsr[k] <= 8'(k * 7 + 1);
        end else if (gen_enable) begin
            for (int k = 0; k < LANES; k++)
                lfsr[k] <= {lfsr[k][6:0], 1'b0} ^ (lfsr[k][7] ? 8'h1D : 8'h00);
        end
    end

    always_comb begin
        real_data = '0;
        for (int k = 0; k < LANES; k++)
            real_data[k*ELEM_W +: ELEM_W] = 8'((16'(lfsr[k]) * (16'(gen_max_val) + 16'd1)) >> 8);
        rand_data = use_real ? real_data : stub_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stub(input int base);
        for (int k = 0; k < LANES; k++) stub_data[k*ELEM_W +: ELEM_W] = 8'(base + k);
    endtask

    task automatic send_req(input int r, input int c, input int m);
        bus.req_rows  = 3'(r);
        bus.req_cols  = 3'(c);
        bus.req_max   = 8'(m);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({bus.req_ready, busy, gen_enable, bus.out_valid, bus.out_last, err_dim} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 100000",
                     {bus.req_ready, busy, gen_enable, bus.out_valid, bus.out_last, err_dim});
        end
        vectors++;
        if ({gen_max_val, bus.out_row, bus.out_col} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_data got max=%0d row=%0d col=%0d want 0/0/0",
                     gen_max_val, bus.out_row, bus.out_col);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] got, exp;
        set_stub(10);
        bus.out_ready = 1'b1;
        send_req(2, 3, 99);
        for (int c = 1; c <= 4; c++) begin
            vectors++;
            if ({gen_enable, bus.out_valid, busy} !== {1'(c <= STIR), 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL basic_stir_c%0d got %b want %b", c,
                         {gen_enable, bus.out_valid, busy}, {1'(c <= STIR), 1'b0, 1'b1});
            end
            step();
        end
        vectors++;
        if (gen_max_val !== 8'd99) begin
            miscompares++;
            $display("FAIL basic_maxval got %0d want 99", gen_max_val);
        end
        for (int e = 0; e < 6; e++) begin
            got = {bus.out_valid, bus.out_last, bus.out_row, bus.out_col, bus.out_data};
            exp = {1'b1, 1'(e == 5), 3'(e / 3), 3'(e % 3), 8'(10 + e)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL basic_elem%0d got %h want %h", e, got, exp);
            end
            step();
        end
        vectors++;
        if ({bus.req_ready, bus.out_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_done got %b want 100", {bus.req_ready, bus.out_valid, busy});
        end
    endtask

    task automatic test_stall();
        logic [15:0] got, exp;
        int n;
        set_stub(10);
        bus.out_ready = 1'b0;
        send_req(2, 3, 99);
        for (int c = 1; c <= 4; c++) step();
        set_stub(200);
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            bus.out_ready = 1'((i % 3) == 0);
            got = {bus.out_valid, bus.out_last, bus.out_row, bus.out_col, bus.out_data};
            exp = {1'b1, 1'(n == 5), 3'(n / 3), 3'(n % 3), 8'(10 + n)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stall_cyc%0d got %h want %h", i, got, exp);
            end
            if (bus.out_ready) n++;
            step();
        end
        bus.out_ready = 1'b1;
        vectors++;
        if ({n, bus.out_valid} !== {32'd6, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_count got %0d transfers valid=%b want 6 valid=0", n, bus.out_valid);
        end
        set_stub(10);
    endtask

    task automatic test_illegal();
        logic [15:0] got, exp;
        int bad_r [2] = '{0, 2};
        int bad_c [2] = '{2, 6};
        bus.out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            send_req(bad_r[t], bad_c[t], 7);
            vectors++;
            if ({err_dim, gen_enable, bus.req_ready, busy, gen_max_val} !== {4'b1010, 8'd99}) begin
                miscompares++;
                $display("FAIL illegal%0d_pulse got %b max=%0d want 1010 max=99", t,
                         {err_dim, gen_enable, bus.req_ready, busy}, gen_max_val);
            end
            step();
            vectors++;
            if ({err_dim, gen_enable} !== 2'b00) begin
                miscompares++;
                $display("FAIL illegal%0d_after got %b want 00", t, {err_dim, gen_enable});
            end
        end
        send_req(5, 5, 50);
        for (int c = 1; c <= 4; c++) step();
        for (int e = 0; e < 25; e++) begin
            got = {bus.out_valid, bus.out_last, bus.out_row, bus.out_col, bus.out_data};
            exp = {1'b1, 1'(e == 24), 3'(e / 5), 3'(e % 5), 8'(10 + e)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL full_elem%0d got %h want %h", e, got, exp);
            end
            step();
        end
        vectors++;
        if ({bus.req_ready, bus.out_valid, gen_max_val} !== {2'b10, 8'd50}) begin
            miscompares++;
            $display("FAIL full_done got rdy/vld=%b max=%0d want 10 max=50",
                     {bus.req_ready, bus.out_valid}, gen_max_val);
        end
    endtask

    task automatic test_abort();
        logic [15:0] got, exp;
        bus.out_ready = 1'b1;
        send_req(2, 3, 42);
        step();
        vectors++;
        if (gen_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_stir_pre got gen_enable=%b want 1", gen_enable);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({gen_enable, bus.out_valid, busy, bus.req_ready, gen_max_val} !== {4'b0001, 8'd42}) begin
            miscompares++;
            $display("FAIL abort_stir got %b max=%0d want 0001 max=42",
                     {gen_enable, bus.out_valid, busy, bus.req_ready}, gen_max_val);
        end
        step();
        vectors++;
        if ({gen_enable, bus.out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_stir_hold got %b want 00", {gen_enable, bus.out_valid});
        end
        send_req(2, 3, 43);
        for (int c = 1; c <= 4; c++) step();
        for (int e = 0; e < 3; e++) step();
        got = {bus.out_valid, bus.out_last, bus.out_row, bus.out_col, bus.out_data};
        exp = {1'b1, 1'b0, 3'd1, 3'd0, 8'd13};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL abort_elem3 got %h want %h", got, exp);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({bus.out_valid, bus.out_last, busy, bus.req_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL abort_stream got %b want 0001",
                     {bus.out_valid, bus.out_last, busy, bus.req_ready});
        end
        step();
        vectors++;
        if ({bus.out_valid, bus.out_last} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_stream_hold got %b want 00", {bus.out_valid, bus.out_last});
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] got, exp;
        bus.out_ready = 1'b1;
        send_req(2, 3, 77);
        for (int c = 1; c <= 4; c++) step();
        step();
        step();
        vectors++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 8'd12}) begin
            miscompares++;
            $display("FAIL rstmid_pre got vld=%b data=%0d want 1/12", bus.out_valid, bus.out_data);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.out_valid, busy, bus.req_ready, gen_enable, gen_max_val, bus.out_row, bus.out_col}
            !== {4'b0010, 8'd0, 6'd0}) begin
            miscompares++;
            $display("FAIL rstmid_async got %b max=%0d row=%0d col=%0d want 0010/0/0/0",
                     {bus.out_valid, busy, bus.req_ready, gen_enable}, gen_max_val,
                     bus.out_row, bus.out_col);
        end
        rst = 1'b0;
        send_req(2, 2, 5);
        for (int c = 1; c <= 4; c++) step();
        for (int e = 0; e < 4; e++) begin
            got = {bus.out_valid, bus.out_last, bus.out_row, bus.out_col, bus.out_data};
            exp = {1'b1, 1'(e == 3), 3'(e / 2), 3'(e % 2), 8'(10 + e)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rstmid_elem%0d got %h want %h", e, got, exp);
            end
            step();
        end
    endtask

    task automatic test_real_unit();
        logic [7:0] first;
        int         distinct;
        use_real = 1'b1;
        bus.out_ready = 1'b1;
        send_req(5, 5, 0);
        for (int c = 1; c <= 4; c++) step();
        for (int e = 0; e < 25; e++) begin
            vectors++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, 8'd0}) begin
                miscompares++;
                $display("FAIL real_max0_elem%0d got vld=%b data=%0d want 1/0", e,
                         bus.out_valid, bus.out_data);
            end
            step();
        end
        send_req(5, 5, 255);
        for (int c = 1; c <= 4; c++) step();
        first = bus.out_data;
        distinct = 0;
        for (int e = 0; e < 25; e++) begin
            vectors++;
            if ({bus.out_valid, bus.out_last} !== {1'b1, 1'(e == 24)}) begin
                miscompares++;
                $display("FAIL real_max255_elem%0d got vld/last=%b want 1%b", e,
                         {bus.out_valid, bus.out_last}, 1'(e == 24));
            end
            if (bus.out_data !== first) distinct++;
            step();
        end
        vectors++;
        if (distinct == 0) begin
            miscompares++;
            $display("FAIL real_max255_spread got all 25 equal to %0d want differing values", first);
        end
        use_real = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_rows  = 3'd0;
        bus.req_cols  = 3'd0;
        bus.req_max   = 8'd0;
        bus.out_ready = 1'b0;
        set_stub(10);
        test_reset();
        test_basic();
        test_stall();
        test_illegal();
        test_abort();
        test_reset_midstream();
        test_real_unit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
